enoc_switch_control_credit: RTL and testbench
=============================================

# enoc_switch_control_credit

Credit-based successor to the ENoC crossbar switch controller. It arbitrates N router input units onto M output ports using one round-robin arbiter per output. Flow control uses per-output credit counters instead of a valid/enable hold signal. A wormhole lock holds each output for a multi-flit packet until its tail flit passes. The block sits between the input units and the crossbar select logic of an ENoC router.

## Interface
Parameters:
- N, 5, number of input ports
- M, 5, number of output ports
- CREDITS, 4, downstream buffer depth per output (≥1); initial and maximum credit count
- CW, $clog2(CREDITS+1), credit counter width (derived, not overridden)

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- ce  input  1  clock enable; all state frozen and all grants zero when low
- i_output_req  input  [0:N-1][0:M-1]  per-input one-hot (or zero) output request
- i_tail  input  [0:N-1]  requesting flit of input i is a packet tail (single-flit packet: head=tail)
- i_credit_return  input  [0:M-1]  one-cycle pulse: downstream freed one buffer slot on output j
- o_output_grant  output  [0:M-1][0:N-1]  output j grants input i (one-hot or zero per output)
- o_credit_count  output  [0:M-1][CW-1:0]  current credits per output
- o_locked  output  [0:M-1]  output j held by an in-progress packet
- o_credit_err  output  [0:M-1]  sticky: credit returned while counter already at CREDITS

## Operation
- Request matrix is transposed per output: req[j][i] = i_output_req[i][j].
- Output j is eligible only if credit[j] > 0 and ce = 1.
- Unlocked output: round-robin among requesting inputs, starting from pointer ptr[j]. A grant to input i sets ptr[j] = (i+1) mod N.
- Lock: a grant to input i with i_tail[i]=0 sets lock[j]=1 and owner[j]=i. While locked, only owner[j] is considered. If the owner is not requesting, no grant is issued (bubble) and the lock stays set.
- Lock release: a granted flit with i_tail=1 clears lock[j] at the next edge. ptr[j] updates only on an unlocked grant or a tail grant, never mid-packet.
- Credit update per edge (ce=1):
  - grant only: −1
  - return only: +1
  - both: unchanged
  - return at CREDITS with no grant: counter holds and o_credit_err[j] sets. The flag stays set until reset.
- Counter never underflows, because no grant is issued at 0.
- Rows of i_output_req with more than one bit set are illegal. Bench asserts this; RTL behaviour is unspecified.
- ce=0: grants forced zero; counters, pointers, locks and error flags hold; credit returns ignored. Upstream guarantees returns occur only while ce=1.

## Timing
- o_output_grant is combinational from inputs and registered state: zero-cycle latency request→grant.
- Credit, lock, pointer and error state update on the rising clk edge in which ce=1.
- A credit returned in cycle t is usable for a grant in cycle t+1.
- Lock takes effect from the cycle after the head grant.
- Reset values (asynchronous, immediate on reset_n low):
  - credit = CREDITS
  - ptr = 0 (input 0 highest priority)
  - lock = 0, owner = 0
  - o_credit_err = 0
  - o_output_grant = 0 while reset_n low
- Reset mid-packet drops all locks and restores full credits; in-flight packets are the system's responsibility.
- Pointer wrap: a grant to input N−1 sets ptr to 0.

## Test plan
- Reset: assert reset_n low mid-traffic → all o_credit_count = 4, o_locked = 0, grants 0. After release, the first contention on any output grants input 0.
- Round robin: inputs 0, 2, 4 request output 1 every cycle with single-flit packets and a return pulse every cycle → grant sequence 0, 2, 4, 0, 2 (pointer wraps).
- Credit exhaustion: input 1 streams single flits to output 3, no returns → exactly 4 grants, then none, count = 0. One return pulse → exactly one grant in the following cycle.
- Wormhole lock: input 3 sends a 3-flit packet (tail on third) to output 2 while input 1 also requests output 2 → grants 3, 3, 3, then 1. o_locked[2] is high for the cycles after the head up to the tail edge. If input 3 deasserts for one cycle mid-packet → bubble, no grant to 1.
- Simultaneous events: count 2, grant and return on output 0 in the same cycle → count stays 2. Return at count 4 with no grant → count 4, o_credit_err[0] = 1 and stays set.
- Clock enable: ce low for 3 cycles with requests and returns present → grants 0, all counters, locks and pointers unchanged. Behaviour resumes identically when ce returns high.

Source files
------------

// File: rtl/enoc_switch_control_credit.sv
// rtl/enoc_switch_control_credit.sv - credit-based ENoC crossbar switch controller
//
// Purpose:
//   Arbitrates N router input units onto M output ports. Each output has its
//   own round-robin arbiter, a downstream credit counter and a wormhole lock
//   that keeps the output with one input until that packet's tail flit passes.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   ce               clock enable; state frozen and grants zero while low
//   i_output_req     [0:N-1][0:M-1] per-input one-hot (or zero) output request
//   i_tail           [0:N-1] requesting flit of input i is a packet tail
//   i_credit_return  [0:M-1] one-cycle pulse, downstream freed a slot on output j
//   o_output_grant   [0:M-1][0:N-1] output j grants input i (combinational)
//   o_credit_count   [0:M-1][CW-1:0] current credits per output
//   o_locked         [0:M-1] output j held by an in-progress packet
//   o_credit_err     [0:M-1] sticky credit-overflow flag per output

module enoc_switch_control_credit #(
  parameter int N       = 5,
  parameter int M       = 5,
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic [0:N-1][0:M-1]     i_output_req,
  input  logic [0:N-1]            i_tail,
  input  logic [0:M-1]            i_credit_return,
  output logic [0:M-1][0:N-1]     o_output_grant,
  output logic [0:M-1][CW-1:0]    o_credit_count,
  output logic [0:M-1]            o_locked,
  output logic [0:M-1]            o_credit_err
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [NW-1:0] LAST_IN  = NW'(N - 1);

  // Registered per-output state
  logic [0:M-1][CW-1:0] credit_q, credit_d;
  logic [0:M-1][NW-1:0] ptr_q,    ptr_d;
  logic [0:M-1][NW-1:0] owner_q,  owner_d;
  logic [0:M-1]         lock_q,   lock_d;
  logic [0:M-1]         err_q,    err_d;

  // Arbitration results
  logic [0:M-1][0:N-1]  req_t;
  logic [0:M-1][0:N-1]  grant;
  logic [0:M-1]         gnt_any;
  logic [0:M-1][NW-1:0] gnt_idx;
  logic [0:M-1]         gnt_tail;

  // Transpose so each output sees its own request column
  always_comb begin
    req_t = '0;
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) begin
        req_t[j][i] = i_output_req[i][j];
      end
    end
  end

  // Per-output arbiter. Grants are gated by reset so nothing leaks out while
  // reset_n is low even though requests are combinational inputs.
  always_comb begin
    int  idx;
    logic found;
    grant    = '0;
    gnt_any  = '0;
    gnt_idx  = '0;
    gnt_tail = '0;
    idx      = 0;
    found    = 1'b0;
    for (int j = 0; j < M; j++) begin
      found = 1'b0;
      if (reset_n && ce && (credit_q[j] != '0)) begin
        if (lock_q[j]) begin
          // Mid-packet: only the owner may continue; otherwise a bubble.
          for (int i = 0; i < N; i++) begin
            if ((NW'(i) == owner_q[j]) && req_t[j][i]) begin
              found       = 1'b1;
              grant[j][i] = 1'b1;
              gnt_idx[j]  = NW'(i);
              gnt_tail[j] = i_tail[i];
            end
          end
        end else begin
          // Round-robin scan starting at the pointer, wrapping at N.
          for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q[j]) + k;
            if (idx >= N) begin
              idx = idx - N;
            end
            if (!found && req_t[j][idx]) begin
              found         = 1'b1;
              grant[j][idx] = 1'b1;
              gnt_idx[j]    = NW'(idx);
              gnt_tail[j]   = i_tail[idx];
            end
          end
        end
      end
      gnt_any[j] = found;
    end
  end

  // Next-state: credits, pointer, lock, owner, error flag
  always_comb begin
    credit_d = credit_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    lock_d   = lock_q;
    err_d    = err_q;
    if (ce) begin
      for (int j = 0; j < M; j++) begin
        // Simultaneous grant and return cancel out.
        if (gnt_any[j] && !i_credit_return[j]) begin
          credit_d[j] = credit_q[j] - CW'(1);
        end else if (!gnt_any[j] && i_credit_return[j]) begin
          if (credit_q[j] == CRED_MAX) begin
            err_d[j] = 1'b1;
          end else begin
            credit_d[j] = credit_q[j] + CW'(1);
          end
        end

        if (gnt_any[j]) begin
          if (gnt_tail[j]) begin
            lock_d[j] = 1'b0;
            ptr_d[j]  = (gnt_idx[j] == LAST_IN) ? '0 : gnt_idx[j] + NW'(1);
          end else begin
            // Head flit moves the pointer; body flits leave it alone.
            if (!lock_q[j]) begin
              ptr_d[j] = (gnt_idx[j] == LAST_IN) ? '0 : gnt_idx[j] + NW'(1);
            end
            lock_d[j]  = 1'b1;
            owner_d[j] = gnt_idx[j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q <= {M{CRED_MAX}};
      ptr_q    <= '0;
      owner_q  <= '0;
      lock_q   <= '0;
      err_q    <= '0;
    end else begin
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  assign o_output_grant = grant;
  assign o_credit_count = credit_q;
  assign o_locked       = lock_q;
  assign o_credit_err   = err_q;

endmodule

// File: tb/tb_enoc_switch_control_credit.sv
// tb/tb_enoc_switch_control_credit.sv - scoreboard bench for enoc_switch_control_credit

module tb_enoc_switch_control_credit;

  localparam int N  = 5;
  localparam int M  = 5;
  localparam int CR = 4;
  localparam int CW = $clog2(CR + 1);

  logic                 clk;
  logic                 reset_n;
  logic                 ce;
  logic [0:N-1][0:M-1]  i_output_req;
  logic [0:N-1]         i_tail;
  logic [0:M-1]         i_credit_return;
  logic [0:M-1][0:N-1]  o_output_grant;
  logic [0:M-1][CW-1:0] o_credit_count;
  logic [0:M-1]         o_locked;
  logic [0:M-1]         o_credit_err;

  enoc_switch_control_credit #(.N(N), .M(M), .CREDITS(CR)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ce              (ce),
    .i_output_req    (i_output_req),
    .i_tail          (i_tail),
    .i_credit_return (i_credit_return),
    .o_output_grant  (o_output_grant),
    .o_credit_count  (o_credit_count),
    .o_locked        (o_locked),
    .o_credit_err    (o_credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    j;
    int    gi;   // expected granted input, -1 for none
    int    cnt;
    bit    lk;
    bit    er;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic int dec_grant(input logic [0:N-1] v);
    int n;
    int g;
    n = 0;
    g = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        n++;
        g = i;
      end
    end
    if (n > 1) g = -2;
    return g;
  endfunction

  task automatic chk(input string nm, input string what, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %0d, required %0d (t=%0t)", nm, what, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      checks++;
      if (!$onehot0(i_output_req[i])) begin
        errors++;
        $display("FAIL req_onehot row %0d: got %b, required at most one bit set", i, i_output_req[i]);
      end
    end
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.nm, "grant", dec_grant(o_output_grant[mon_e.j]), mon_e.gi);
      chk(mon_e.nm, "credit", int'(o_credit_count[mon_e.j]), mon_e.cnt);
      chk(mon_e.nm, "locked", int'(o_locked[mon_e.j]), int'(mon_e.lk));
      chk(mon_e.nm, "err", int'(o_credit_err[mon_e.j]), int'(mon_e.er));
    end
  end

  task automatic expect_out(input string nm, input int j, input int gi, input int cnt,
                            input bit lk, input bit er);
    exp_t e;
    e.nm = nm; e.j = j; e.gi = gi; e.cnt = cnt; e.lk = lk; e.er = er;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_output_req    = '0;
    i_tail          = '0;
    i_credit_return = '0;
  endtask

  int rr_seq[5] = '{0, 2, 4, 0, 2};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    ce      = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    expect_out("init_rst0", 0, -1, 4, 0, 0);
    expect_out("init_rst3", 3, -1, 4, 0, 0);
    tick();
    reset_n = 1'b1;

    // Round robin on output 1 with pointer wrap
    clr();
    i_output_req[0][1] = 1'b1; i_output_req[2][1] = 1'b1; i_output_req[4][1] = 1'b1;
    i_tail[0] = 1'b1; i_tail[2] = 1'b1; i_tail[4] = 1'b1;
    i_credit_return[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_out("rr", 1, rr_seq[k], 4, 0, 0);
      tick();
    end

    // Credit exhaustion on output 3
    clr();
    i_output_req[1][3] = 1'b1; i_tail[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_out("exh", 3, 1, 4 - k, 0, 0);
      tick();
    end
    expect_out("exh_empty", 3, -1, 0, 0, 0); tick();
    expect_out("exh_empty", 3, -1, 0, 0, 0); tick();
    i_credit_return[3] = 1'b1;
    expect_out("exh_ret", 3, -1, 0, 0, 0); tick();
    i_credit_return[3] = 1'b0;
    expect_out("exh_regrant", 3, 1, 1, 0, 0); tick();
    expect_out("exh_done", 3, -1, 0, 0, 0); tick();

    // Wormhole lock on output 2 with a mid-packet bubble
    clr();
    i_output_req[3][2] = 1'b1;
    expect_out("wh_head", 2, 3, 4, 0, 0); tick();
    i_output_req[1][2] = 1'b1; i_tail[1] = 1'b1;
    expect_out("wh_body", 2, 3, 3, 1, 0); tick();
    i_output_req[3][2] = 1'b0;
    expect_out("wh_bubble", 2, -1, 2, 1, 0); tick();
    i_output_req[3][2] = 1'b1; i_tail[3] = 1'b1;
    expect_out("wh_tail", 2, 3, 2, 1, 0); tick();
    i_output_req[3][2] = 1'b0;
    expect_out("wh_next", 2, 1, 1, 0, 0); tick();
    clr();
    expect_out("wh_after", 2, -1, 0, 0, 0); tick();

    // Simultaneous grant/return and overflow error on output 0
    i_output_req[0][0] = 1'b1; i_tail[0] = 1'b1;
    expect_out("sim_g", 0, 0, 4, 0, 0); tick();
    expect_out("sim_g", 0, 0, 3, 0, 0); tick();
    i_credit_return[0] = 1'b1;
    expect_out("sim_both", 0, 0, 2, 0, 0); tick();
    i_output_req[0][0] = 1'b0;
    expect_out("sim_ret", 0, -1, 2, 0, 0); tick();
    expect_out("sim_ret", 0, -1, 3, 0, 0); tick();
    expect_out("sim_ovf", 0, -1, 4, 0, 0); tick();
    i_credit_return[0] = 1'b0;
    expect_out("sim_err", 0, -1, 4, 0, 1); tick();
    expect_out("sim_err_sticky", 0, -1, 4, 0, 1); tick();

    // Clock enable: head on output 4 first so a lock is held across ce=0
    clr();
    i_output_req[4][4] = 1'b1;
    expect_out("ce_pre", 4, 4, 4, 0, 0); tick();
    ce = 1'b0;
    i_output_req[2][4] = 1'b1;
    i_output_req[3][1] = 1'b1; i_output_req[0][1] = 1'b1;
    i_tail[3] = 1'b1; i_tail[0] = 1'b1;
    i_credit_return[3] = 1'b1; i_credit_return[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_out("ce_off1", 1, -1, 4, 0, 0);
      expect_out("ce_off3", 3, -1, 0, 0, 0);
      expect_out("ce_off4", 4, -1, 3, 1, 0);
      expect_out("ce_off0", 0, -1, 4, 0, 1);
      tick();
    end
    ce = 1'b1;
    i_credit_return[3] = 1'b0; i_credit_return[0] = 1'b0;
    expect_out("ce_on1", 1, 3, 4, 0, 0);
    expect_out("ce_on3", 3, -1, 0, 0, 0);
    expect_out("ce_on4", 4, 4, 3, 1, 0);
    tick();

    // Reset in the middle of a locked packet
    clr();
    i_output_req[4][4] = 1'b1;
    expect_out("pre_rst", 4, 4, 2, 1, 0); tick();
    reset_n = 1'b0;
    expect_out("rst4", 4, -1, 4, 0, 0);
    expect_out("rst2", 2, -1, 4, 0, 0);
    expect_out("rst0", 0, -1, 4, 0, 0);
    expect_out("rst3", 3, -1, 4, 0, 0);
    tick();
    reset_n = 1'b1;
    clr();
    i_output_req[0][4] = 1'b1; i_output_req[2][4] = 1'b1;
    i_output_req[3][1] = 1'b1; i_output_req[4][1] = 1'b1;
    i_tail = '1;
    expect_out("post_rst4", 4, 0, 4, 0, 0);
    expect_out("post_rst1", 1, 3, 4, 0, 0);
    tick();

    clr();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
